ps2_kbd_ctrl: RTL and testbench

//  PS/2 keyboard receive controller between raw ps2_clk/ps2_dat pins and the consumer (7-seg/UART/CPU MMIO).
//  - Oversamples the PS/2 pins on the system clock and assembles 11-bit frames.
//  - Checks each frame, decodes E0/F0 prefixes into key events and buffers them in a FIFO.
//  - Consumer pops events with a valid/ready handshake; also keeps a key-release counter.

---
 rtl/ps2_kbd_if.sv | 25 ++
 rtl/ps2_kbd_ctrl.sv | 160 ++++++++++++++++
 tb/tb_ps2_kbd_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/ps2_kbd_if.sv
// Event-side bundle of the PS/2 keyboard controller: raw pins in, decoded key events out.
// The controller takes the master modport and the consumer takes the slave modport.
interface ps2_kbd_if;
    logic       ps2_clk;
    logic       ps2_dat;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_brk;
    logic       evt_ext;
    logic       overflow;
    logic       ovf_clr;
    logic       frame_err;
    logic [7:0] rel_cnt;

    modport master (
        input  ps2_clk, ps2_dat, evt_ready, ovf_clr,
        output evt_valid, evt_code, evt_brk, evt_ext, overflow, frame_err, rel_cnt
    );

    modport slave (
        output ps2_clk, ps2_dat, evt_ready, ovf_clr,
        input  evt_valid, evt_code, evt_brk, evt_ext, overflow, frame_err, rel_cnt
    );
endinterface

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard receiver: synchronises the pins, assembles and checks 11-bit frames,
// folds E0/F0 prefixes into key events and queues them in a fall-through FIFO.
module ps2_kbd_ctrl #(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       clrn,
    ps2_kbd_if.master  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] IDLE_ONE  = TW'(1);
    localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);

    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          clk_dly_q;
    logic          fall, dat_s;

    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [10:0]   frame_q, frame_d, frame_full;
    logic [TW-1:0] idle_q, idle_d;
    logic [7:0]    code_q, code_d;
    logic          code_vld_q, code_vld_d;
    logic          frame_err_q, frame_err_d;

    logic          ext_q, ext_d, brk_q, brk_d;
    logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic          ovf_q, ovf_d;
    logic [7:0]    rel_q, rel_d;
    logic          empty, full, pop, push, push_req, is_prefix;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_dly_q  <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], bus.ps2_clk};
            dat_sync_q <= {dat_sync_q[0], bus.ps2_dat};
            clk_dly_q  <= clk_sync_q[1];
        end
    end

    assign fall  = !clk_sync_q[1] && clk_dly_q;
    assign dat_s = dat_sync_q[1];

    // Frame assembly; frame_full is the frame including the bit captured on this fall.
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        frame_d     = frame_q;
        idle_d      = idle_q;
        code_d      = code_q;
        code_vld_d  = 1'b0;
        frame_err_d = 1'b0;
        frame_full  = frame_q;
        frame_full[bit_cnt_q] = dat_s;
        if (fall) begin
            idle_d = '0;
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = 4'd0;
                if (!frame_full[0] && frame_full[10] && (^frame_full[9:1])) begin
                    code_vld_d = 1'b1;
                    code_d     = frame_full[8:1];
                end else begin
                    frame_err_d = 1'b1;
                end
            end else begin
                frame_d   = frame_full;
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (idle_q == IDLE_LAST) begin
                idle_d      = '0;
                bit_cnt_d   = 4'd0;
                frame_err_d = 1'b1;
            end else begin
                idle_d = idle_q + IDLE_ONE;
            end
        end else begin
            idle_d = '0;
        end
    end

    assign empty     = (wr_q == rd_q);
    assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop       = bus.evt_ready && !empty;
    assign is_prefix = (code_q == 8'hE0) || (code_q == 8'hF0);
    assign push_req  = code_vld_q && !is_prefix;
    assign push      = push_req && (!full || pop);

    // Prefix flags are consumed by any non-prefix code, even one the full FIFO drops.
    always_comb begin
        ext_d = ext_q;
        brk_d = brk_q;
        wr_d  = push ? wr_q + PTR_ONE : wr_q;
        rd_d  = pop ? rd_q + PTR_ONE : rd_q;
        rel_d = (push && brk_q) ? rel_q + 8'd1 : rel_q;
        ovf_d = ovf_q;
        if (frame_err_q) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (code_vld_q) begin
            case (code_q)
                8'hE0:   ext_d = 1'b1;
                8'hF0:   brk_d = 1'b1;
                default: begin
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
            endcase
        end
        if (push_req && full && !pop)
            ovf_d = 1'b1;
        else if (bus.ovf_clr)
            ovf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            bit_cnt_q   <= '0;
            frame_q     <= '0;
            idle_q      <= '0;
            code_q      <= '0;
            code_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            wr_q        <= '0;
            rd_q        <= '0;
            ovf_q       <= 1'b0;
            rel_q       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            frame_q     <= frame_d;
            idle_q      <= idle_d;
            code_q      <= code_d;
            code_vld_q  <= code_vld_d;
            frame_err_q <= frame_err_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            ovf_q       <= ovf_d;
            rel_q       <= rel_d;
            if (push)
                mem_q[wr_q[AW-1:0]] <= {ext_q, brk_q, code_q};
        end
    end

    assign bus.evt_valid = !empty;
    assign {bus.evt_ext, bus.evt_brk, bus.evt_code} = mem_q[rd_q[AW-1:0]];
    assign bus.overflow  = ovf_q;
    assign bus.frame_err = frame_err_q;
    assign bus.rel_cnt   = rel_q;
endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Scoreboard bench for ps2_kbd_ctrl: directed PS/2 frames push expected events into a queue,
// and a monitor compares every popped event against it.
module tb_ps2_kbd_ctrl;
    localparam int HALF    = 20;
    localparam int TIMEOUT = 50000;

    logic clk  = 1'b0;
    logic clrn = 1'b0;
    always #5 clk = ~clk;

    ps2_kbd_if bus ();

    ps2_kbd_ctrl #(.FIFO_DEPTH(8), .TIMEOUT_CYC(TIMEOUT)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    int         checks    = 0;
    int         errors    = 0;
    int         cycleCnt  = 0;
    int         stopFall  = 0;
    int         riseCycle = 0;
    int         errPulses = 0;
    logic       prevValid = 1'b0;
    logic [9:0] expQ [$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cycleCnt++;

    always @(posedge clk) begin
        #1;
        if (bus.evt_valid && !prevValid)
            riseCycle = cycleCnt;
        prevValid = bus.evt_valid;
    end

    always @(negedge clk) begin
        if (clrn && bus.frame_err)
            errPulses++;
        if (clrn && bus.evt_valid && bus.evt_ready) begin
            if (expQ.size() == 0)
                checkOutput("unexpected_evt", {22'd0, bus.evt_ext, bus.evt_brk, bus.evt_code}, 32'hFFFF);
            else
                checkOutput("evt", {22'd0, bus.evt_ext, bus.evt_brk, bus.evt_code},
                            {22'd0, expQ.pop_front()});
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sendBits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            bus.ps2_dat = bits[i];
            waitCycles(HALF);
            bus.ps2_clk = 1'b0;
            if (i == 10) stopFall = cycleCnt;
            waitCycles(HALF);
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_dat = 1'b1;
        waitCycles(HALF);
    endtask

    function automatic logic [10:0] makeFrame(input logic [7:0] code, input logic badPar,
                                              input logic stopBit);
        return {stopBit, (~^code) ^ badPar, code, 1'b0};
    endfunction

    task automatic applyStimulus(input logic [7:0] code, input logic badPar = 1'b0,
                                 input logic stopBit = 1'b1);
        sendBits(makeFrame(code, badPar, stopBit), 11);
    endtask

    task automatic popAll();
        bus.evt_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            waitCycles(1);
            if (!bus.evt_valid) break;
        end
        bus.evt_ready = 1'b0;
        checkOutput("drained", {31'd0, bus.evt_valid}, 32'd0);
    endtask

    initial begin
        int errBase;
        logic [7:0] codes [9];
        codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};

        bus.ps2_clk   = 1'b1;
        bus.ps2_dat   = 1'b1;
        bus.evt_ready = 1'b0;
        bus.ovf_clr   = 1'b0;
        waitCycles(5);
        checkOutput("rst_valid", {31'd0, bus.evt_valid}, 32'd0);
        checkOutput("rst_ovf", {31'd0, bus.overflow}, 32'd0);
        checkOutput("rst_ferr", {31'd0, bus.frame_err}, 32'd0);
        checkOutput("rst_rel", {24'd0, bus.rel_cnt}, 32'd0);
        clrn = 1'b1;
        waitCycles(5);

        $display("[TB] T1 single make code");
        applyStimulus(8'h1C);
        expQ.push_back({2'b00, 8'h1C});
        checkOutput("t1_latency", riseCycle - stopFall, 32'd4);
        checkOutput("t1_valid", {31'd0, bus.evt_valid}, 32'd1);
        checkOutput("t1_head", {22'd0, bus.evt_ext, bus.evt_brk, bus.evt_code}, {22'd0, 2'b00, 8'h1C});
        popAll();

        $display("[TB] T2 release");
        applyStimulus(8'hF0);
        applyStimulus(8'h1C);
        expQ.push_back({2'b01, 8'h1C});
        checkOutput("t2_rel", {24'd0, bus.rel_cnt}, 32'd1);
        popAll();
        checkOutput("t2_queue", expQ.size(), 32'd0);

        $display("[TB] T3 extended release");
        applyStimulus(8'hE0);
        applyStimulus(8'hF0);
        applyStimulus(8'h75);
        expQ.push_back({2'b11, 8'h75});
        applyStimulus(8'h1C);
        expQ.push_back({2'b00, 8'h1C});
        popAll();
        checkOutput("t3_rel", {24'd0, bus.rel_cnt}, 32'd2);

        $display("[TB] T4 bad frames");
        errBase = errPulses;
        applyStimulus(8'h16, 1'b1, 1'b1);
        applyStimulus(8'h1C, 1'b0, 1'b0);
        checkOutput("t4_err", errPulses - errBase, 32'd2);
        checkOutput("t4_empty", {31'd0, bus.evt_valid}, 32'd0);
        checkOutput("t4_rel", {24'd0, bus.rel_cnt}, 32'd2);

        $display("[TB] T5 overflow");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(codes[i]);
            if (i < 8) expQ.push_back({2'b00, codes[i]});
            if (i == 7) checkOutput("t5_ovf_before", {31'd0, bus.overflow}, 32'd0);
        end
        checkOutput("t5_ovf", {31'd0, bus.overflow}, 32'd1);
        popAll();
        checkOutput("t5_queue", expQ.size(), 32'd0);
        checkOutput("t5_ovf_sticky", {31'd0, bus.overflow}, 32'd1);
        bus.ovf_clr = 1'b1;
        waitCycles(1);
        bus.ovf_clr = 1'b0;
        checkOutput("t5_ovf_clr", {31'd0, bus.overflow}, 32'd0);
        checkOutput("t5_rel", {24'd0, bus.rel_cnt}, 32'd2);

        $display("[TB] T6 timeout");
        errBase = errPulses;
        sendBits(makeFrame(8'h33, 1'b0, 1'b1), 5);
        waitCycles(TIMEOUT + 50);
        checkOutput("t6_timeout", errPulses - errBase, 32'd1);
        applyStimulus(8'h45);
        expQ.push_back({2'b00, 8'h45});
        popAll();

        $display("[TB] T6 reset mid-frame");
        applyStimulus(8'hF0);
        applyStimulus(8'h1C);
        checkOutput("t6_rel3", {24'd0, bus.rel_cnt}, 32'd3);
        checkOutput("t6_held", {31'd0, bus.evt_valid}, 32'd1);
        sendBits(makeFrame(8'h29, 1'b0, 1'b1), 3);
        errBase = errPulses;
        clrn = 1'b0;
        #1;
        checkOutput("rst2_valid", {31'd0, bus.evt_valid}, 32'd0);
        checkOutput("rst2_rel", {24'd0, bus.rel_cnt}, 32'd0);
        checkOutput("rst2_ovf", {31'd0, bus.overflow}, 32'd0);
        checkOutput("rst2_ferr", {31'd0, bus.frame_err}, 32'd0);
        expQ.delete();
        waitCycles(3);
        clrn = 1'b1;
        waitCycles(5);
        applyStimulus(8'h1C);
        expQ.push_back({2'b00, 8'h1C});
        popAll();
        checkOutput("rst2_noerr", errPulses - errBase, 32'd0);
        checkOutput("final_queue", expQ.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
